scan_decoder: RTL and testbench

Parametrised, registered N-to-2^N one-hot decoder with two modes. In direct mode it decodes a select input. In scan mode it self-sequences through all outputs with a programmable dwell time and optional blanking gap. It drives multiplexed digit/row enables (e.g. 7-segment digit select) and replaces hand-written fixed 2-to-4 decoders wherever a clocked, glitch-free select is needed.

---
 rtl/scan_decoder_if.sv | 29 ++
 rtl/scan_decoder.sv | 130 +++++++++++++
 tb/tb_scan_decoder.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/scan_decoder_if.sv
// scan_decoder_if: control/select inputs and registered decoder outputs of
// scan_decoder.
//   en   - enable; 0 forces all outputs low
//   mode - 0 = direct decode of sel, 1 = autonomous scan
//   sel  - select index, direct mode only (N bits)
//   D    - one-hot (or all-zero) output, 2^N bits
//   idx  - index of the currently/last lit output (N bits)
//   wrap - one-cycle pulse when the scan returns to index 0
// master drives en/mode/sel; slave (the decoder) drives D/idx/wrap.
interface scan_decoder_if #(
    parameter int unsigned N = 2
);
    logic              en;
    logic              mode;
    logic [N-1:0]      sel;
    logic [(1<<N)-1:0] D;
    logic [N-1:0]      idx;
    logic              wrap;

    modport master (
        output en, mode, sel,
        input  D, idx, wrap
    );

    modport slave (
        input  en, mode, sel,
        output D, idx, wrap
    );
endinterface

// File: rtl/scan_decoder.sv
// scan_decoder: registered N-to-2^N one-hot decoder. Direct mode decodes
// bus.sel; scan mode walks every output in turn, holding each for DIV cycles
// followed by BLANK all-zero cycles.
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset
//   bus  - scan_decoder_if.slave: en/mode/sel in, D/idx/wrap out (all registered)
module scan_decoder #(
    parameter int unsigned N     = 2,
    parameter int unsigned DIV   = 4,
    parameter int unsigned BLANK = 1
) (
    input  logic           clk,
    input  logic           rst,
    scan_decoder_if.slave  bus
);

    localparam int unsigned OUT_W      = 1 << N;
    localparam int unsigned PRE_MAX    = (DIV > BLANK) ? DIV : BLANK;
    localparam int unsigned PRE_W      = (PRE_MAX > 1) ? $clog2(PRE_MAX) : 1;
    localparam int unsigned DIV_LAST   = DIV - 1;
    localparam int unsigned BLANK_LAST = (BLANK > 0) ? BLANK - 1 : 0;
    localparam bit          HAS_GAP    = (BLANK > 0);

    localparam logic [PRE_W-1:0] DIV_END   = PRE_W'(DIV_LAST);
    localparam logic [PRE_W-1:0] BLANK_END = PRE_W'(BLANK_LAST);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DIRECT,
        ST_SHOW,
        ST_BLANK
    } state_e;

    state_e            state_q, state_d;
    logic [OUT_W-1:0]  d_q, d_d;
    logic [N-1:0]      idx_q, idx_d;
    logic              wrap_q, wrap_d;
    logic [PRE_W-1:0]  pre_q, pre_d;
    logic [N-1:0]      sidx_q, sidx_d;
    logic [N-1:0]      sidx_inc;
    logic              advance;

    // Next scan index wraps naturally modulo 2^N.
    assign sidx_inc = sidx_q + N'(1);

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            d_q     <= '0;
            idx_q   <= '0;
            wrap_q  <= 1'b0;
            pre_q   <= '0;
            sidx_q  <= '0;
        end else begin
            state_q <= state_d;
            d_q     <= d_d;
            idx_q   <= idx_d;
            wrap_q  <= wrap_d;
            pre_q   <= pre_d;
            sidx_q  <= sidx_d;
        end
    end

    // Next-state and next-output logic; en=0 dominates, then mode.
    always_comb begin
        state_d = state_q;
        d_d     = d_q;
        idx_d   = idx_q;
        wrap_d  = 1'b0;
        pre_d   = pre_q;
        sidx_d  = sidx_q;
        advance = 1'b0;

        if (!bus.en) begin
            state_d = ST_IDLE;
            d_d     = '0;
            pre_d   = '0;
        end else if (!bus.mode) begin
            state_d = ST_DIRECT;
            d_d     = OUT_W'(1) << bus.sel;
            idx_d   = bus.sel;
            pre_d   = '0;
        end else begin
            unique case (state_q)
                ST_SHOW: begin
                    if (pre_q != DIV_END) begin
                        pre_d = pre_q + PRE_W'(1);
                    end else if (HAS_GAP) begin
                        state_d = ST_BLANK;
                        d_d     = '0;
                        pre_d   = '0;
                    end else begin
                        advance = 1'b1;
                    end
                end
                ST_BLANK: begin
                    d_d = '0;
                    if (pre_q != BLANK_END) begin
                        pre_d = pre_q + PRE_W'(1);
                    end else begin
                        advance = 1'b1;
                    end
                end
                default: begin
                    // Entry from IDLE or DIRECT always restarts at index 0.
                    state_d = ST_SHOW;
                    sidx_d  = '0;
                    idx_d   = '0;
                    d_d     = OUT_W'(1);
                    pre_d   = '0;
                end
            endcase

            if (advance) begin
                state_d = ST_SHOW;
                sidx_d  = sidx_inc;
                idx_d   = sidx_inc;
                d_d     = OUT_W'(1) << sidx_inc;
                pre_d   = '0;
                wrap_d  = (sidx_inc == '0);
            end
        end
    end

    assign bus.D    = d_q;
    assign bus.idx  = idx_q;
    assign bus.wrap = wrap_q;

endmodule

// File: tb/tb_scan_decoder.sv
// tb_scan_decoder: two decoder instances (N=2/DIV=3/BLANK=1 and
// N=3/DIV=1/BLANK=0) checked every cycle against a timeline model, plus
// hand-computed expectations for the directed scenarios.
module tb_scan_decoder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst0, rst1;

    scan_decoder_if #(.N(2)) if0 ();
    scan_decoder_if #(.N(3)) if1 ();

    scan_decoder #(.N(2), .DIV(3), .BLANK(1)) u0 (
        .clk (clk),
        .rst (rst0),
        .bus (if0)
    );

    scan_decoder #(.N(3), .DIV(1), .BLANK(0)) u1 (
        .clk (clk),
        .rst (rst1),
        .bus (if1)
    );

    int errors = 0;
    int checks = 0;
    bit chk_on = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Model: scan output is a function of the cycle count t since scan entry.
    int         m_nw    [2] = '{2, 3};
    int         m_div   [2] = '{3, 1};
    int         m_blank [2] = '{1, 0};
    bit         m_scan  [2] = '{0, 0};
    int         m_t     [2] = '{0, 0};
    logic [7:0] m_d     [2] = '{8'd0, 8'd0};
    int         m_idx   [2] = '{0, 0};
    bit         m_wrap  [2] = '{0, 0};

    task automatic model_step(input int i, input bit r, input bit e, input bit m, input int s);
        int per, pos, slot;
        m_wrap[i] = 1'b0;
        if (r) begin
            m_scan[i] = 1'b0;
            m_d[i]    = 8'd0;
            m_idx[i]  = 0;
        end else if (!e) begin
            m_scan[i] = 1'b0;
            m_d[i]    = 8'd0;
        end else if (!m) begin
            m_scan[i] = 1'b0;
            m_d[i]    = 8'd1 << s;
            m_idx[i]  = s;
        end else begin
            if (!m_scan[i]) begin
                m_scan[i] = 1'b1;
                m_t[i]    = 0;
            end else begin
                m_t[i]++;
            end
            per  = m_div[i] + m_blank[i];
            pos  = m_t[i] % per;
            slot = (m_t[i] / per) % (1 << m_nw[i]);
            m_idx[i]  = slot;
            m_d[i]    = (pos < m_div[i]) ? (8'd1 << slot) : 8'd0;
            m_wrap[i] = (m_t[i] > 0) && (pos == 0) && (slot == 0);
        end
    endtask

    always @(posedge clk) begin
        model_step(0, rst0, if0.en, if0.mode, int'(if0.sel));
        model_step(1, rst1, if1.en, if1.mode, int'(if1.sel));
        chk_on = 1'b1;
    end

    // Per-cycle compare of both instances against the model.
    always @(negedge clk) begin
        if (chk_on) begin
            chk("u0_D",      {4'd0, if0.D}, m_d[0]);
            chk("u0_idx",    if0.idx, m_idx[0]);
            chk("u0_wrap",   if0.wrap, m_wrap[0]);
            chk("u0_onehot", ($countones(if0.D) <= 1), 1);
            chk("u1_D",      if1.D, m_d[1]);
            chk("u1_idx",    if1.idx, m_idx[1]);
            chk("u1_wrap",   if1.wrap, m_wrap[1]);
            chk("u1_onehot", ($countones(if1.D) <= 1), 1);
        end
    end

    logic [3:0] sweep_exp [4]  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    logic [3:0] scan_exp  [17] = '{4'h1, 4'h1, 4'h1, 4'h0, 4'h2, 4'h2, 4'h2, 4'h0,
                                   4'h4, 4'h4, 4'h4, 4'h0, 4'h8, 4'h8, 4'h8, 4'h0, 4'h1};

    initial begin
        bit found;
        rst0 = 1'b1;  rst1 = 1'b1;
        if0.en = 1'b1; if0.mode = 1'b1; if0.sel = '0;
        if1.en = 1'b1; if1.mode = 1'b1; if1.sel = '0;

        // Reset held two cycles with scan requested.
        repeat (2) begin
            @(negedge clk);
            chk("rst_D",    if0.D, 4'b0000);
            chk("rst_idx",  if0.idx, 0);
            chk("rst_wrap", if0.wrap, 0);
        end
        rst0 = 1'b0;
        @(negedge clk);
        chk("rst_rel_D", if0.D, 4'b0001);

        // Direct decode.
        if0.mode = 1'b0; if0.sel = 2'd2;
        @(negedge clk);
        chk("dir_D2",   if0.D, 4'b0100);
        chk("dir_idx2", if0.idx, 2);
        if0.sel = 2'd3;
        @(negedge clk);
        chk("dir_D3", if0.D, 4'b1000);
        for (int s = 0; s < 4; s++) begin
            if0.sel = 2'(s);
            @(negedge clk);
            chk("dir_sweep", if0.D, sweep_exp[s]);
        end

        // Full scan frame from DIRECT.
        if0.mode = 1'b1;
        for (int c = 0; c < 17; c++) begin
            @(negedge clk);
            chk("scan_D",    if0.D, scan_exp[c]);
            chk("scan_wrap", if0.wrap, (c == 16) ? 1 : 0);
        end

        // Disable while index 1 is lit, then re-enable.
        repeat (4) @(negedge clk);
        chk("dis_pre_D", if0.D, 4'b0010);
        if0.en = 1'b0;
        @(negedge clk);
        chk("dis_D",   if0.D, 4'b0000);
        chk("dis_idx", if0.idx, 1);
        if0.en = 1'b1;
        @(negedge clk);
        chk("reen_D",   if0.D, 4'b0001);
        chk("reen_idx", if0.idx, 0);

        // Reset during a blanking gap.
        found = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (if0.D == 4'b0000) begin
                found = 1'b1;
                break;
            end
        end
        chk("gap_found", found, 1);
        rst0 = 1'b1;
        @(negedge clk);
        chk("gaprst_D",    if0.D, 4'b0000);
        chk("gaprst_idx",  if0.idx, 0);
        chk("gaprst_wrap", if0.wrap, 0);
        rst0 = 1'b0;
        @(negedge clk);
        chk("gaprel_D",   if0.D, 4'b0001);
        chk("gaprel_idx", if0.idx, 0);
        @(negedge clk);
        chk("gaprel_hold", if0.D, 4'b0001);

        // No-gap fast scan on the 3-bit instance.
        rst1 = 1'b0;
        for (int c = 0; c < 17; c++) begin
            @(negedge clk);
            chk("fast_D",    if1.D, 8'd1 << (c % 8));
            chk("fast_wrap", if1.wrap, (c == 8 || c == 16) ? 1 : 0);
        end

        // Randomized traffic on both instances.
        repeat (600) begin
            @(negedge clk);
            rst0 = ($urandom_range(0, 31) == 0);
            rst1 = ($urandom_range(0, 31) == 0);
            if0.en = ($urandom_range(0, 7) != 0);
            if1.en = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 15) == 0) if0.mode = ~if0.mode;
            if ($urandom_range(0, 15) == 0) if1.mode = ~if1.mode;
            if0.sel = 2'($urandom_range(0, 3));
            if1.sel = 3'($urandom_range(0, 7));
        end
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
